// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell reused over WIDTH cycles, LSB first,
// with valid/ready handshakes on the operand and result sides.

module serial_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | ((a_i ^ b_i) & c_i);
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;

  serial_adder_fa u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          sum_d   = '0;
          cout_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // abort wins over completion, including on the last bit
        if (abort) begin
          sum_d   = '0;
          carry_d = 1'b0;
          cout_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          sum_d   = {fa_s, sum_q[WIDTH-1:1]};
          carry_d = fa_c;
          a_d     = a_q >> 1;
          b_d     = b_q >> 1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cout_d  = fa_c;
            cnt_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed vector table, abort and
// reset corner sequences, and a randomized sweep against a+b+cin.

module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, cin, abort, out_valid, out_ready, cout, busy;
  logic [W-1:0] a, b, sum;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    int           hold;
    bit           toggle;
    bit           abort_done;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction: accept, run, optional backpressure, result handshake.
  task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                         input int hold, input bit toggle, input bit abort_done,
                         input logic [W-1:0] es, input logic eco);
    int lat;
    int busy_n;
    check("in_ready_idle", 64'(in_ready), 64'd1);
    a = ta; b = tbv; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    if (!toggle) in_valid = 1'b0;
    lat = 0; busy_n = 0;
    while (!out_valid && lat < 4 * W) begin
      if (busy) busy_n++;
      if (in_ready) check("in_ready_during_run", 64'(in_ready), 64'd0);
      if (toggle) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 64'(lat), 64'(W));
    check("busy_cycles", 64'(busy_n), 64'(W));
    check("sum", 64'(sum), 64'(es));
    check("cout", 64'(cout), 64'(eco));
    check("in_ready_done", 64'(in_ready), 64'd0);
    abort = abort_done;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("held_valid", 64'(out_valid), 64'd1);
      check("held_sum", 64'(sum), 64'(es));
      check("held_cout", 64'(cout), 64'(eco));
      check("held_in_ready", 64'(in_ready), 64'd0);
    end
    abort = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_drop", 64'(out_valid), 64'd0);
    check("ready_back", 64'(in_ready), 64'd1);
    check("busy_after", 64'(busy), 64'd0);
    check("sum_kept", 64'(sum), 64'(es));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_sum"}, 64'(sum), 64'd0);
    check({tag, "_cout"}, 64'(cout), 64'd0);
  endtask

  // Starts an addition, aborts on RUN edge number `edge_n`, then proves no result appears.
  task automatic abort_seq(input int edge_n);
    int seen;
    a = 8'hC3; b = 8'h7E; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < edge_n; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    seen = 0;
    for (int i = 0; i < W + 2; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("abort_no_valid", 64'(seen), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   model;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 0, 1'b0, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 0, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 1'b0, 5, 1'b0, 1'b0, 8'h46, 1'b0};
    vecs[5] = '{8'hA5, 8'h0F, 1'b0, 1, 1'b1, 1'b0, 8'hB4, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 3, 1'b0, 1'b1, 8'hFF, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #2;
    check_reset_state("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_noop", 64'(in_ready), 64'd1);

    for (int i = 0; i < 7; i++)
      run_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].hold, vecs[i].toggle,
              vecs[i].abort_done, vecs[i].s, vecs[i].co);

    abort_seq(4);
    run_add(8'h80, 8'h80, 1'b1, 0, 1'b0, 1'b0, 8'h01, 1'b1);
    abort_seq(W);

    // asynchronous reset between clock edges in the middle of a run
    a = 8'h77; b = 8'h99; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("midrun_reset");
    #2 rst_n = 1'b1;
    tick();
    run_add(8'h77, 8'h99, 1'b1, 0, 1'b0, 1'b0, 8'h11, 1'b1);

    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      model = (W + 1)'(ra) + (W + 1)'(rb) + (W + 1)'(rc);
      run_add(ra, rb, rc, $urandom_range(0, 2), ($urandom_range(0, 7) == 0), 1'($urandom),
              model[W-1:0], model[W]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
